// File: rtl/key_matrix_resp.sv
// Key-matrix responder: synchronises and debounces a host key bitmap, answers MCU row strobes
// after a settle delay, and pulses an active-low interrupt on new presses. Ghosting: KEY_MATRIX_GHOST_EN.
module key_matrix_resp #(
  parameter int ROWS     = 8,
  parameter int COLS     = 4,
  parameter int DEBOUNCE = 16,
  parameter int TICK_DIV = 1024,
  parameter int SETTLE   = 2,
  parameter int INT_W    = 8
) (
  input  logic                 clk,
  input  logic                 _reset,
  input  logic [ROWS-1:0]      strobe,
  input  logic [ROWS*COLS-1:0] keys,
  output logic [COLS-1:0]      ret,
  output logic                 _int,
  output logic                 press_evt,
  output logic [ROWS*COLS-1:0] stable_keys
);

  localparam int NK = ROWS * COLS;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int IW = $clog2(INT_W + 1);

  logic [NK-1:0]   sync1, ksync;
  logic [NK-1:0]   stable_next, newpress, eff;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [DW-1:0]   dcnt      [NK];
  logic [DW-1:0]   dcnt_next [NK];
  logic [ROWS-1:0] strobe_q, strobe_q_prev;
  logic [SW-1:0]   settle_cnt;
  logic [IW-1:0]   int_cnt;
  logic [COLS-1:0] m;

  always_comb tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_comb begin
    stable_next = stable_keys;
    for (int unsigned k = 0; k < NK; k++) begin
      dcnt_next[k] = '0;
      if (ksync[k] != stable_keys[k]) begin
        if (tick) begin
          if (dcnt[k] == DW'(DEBOUNCE - 1)) stable_next[k] = ksync[k];
          else                              dcnt_next[k] = dcnt[k] + 1'b1;
        end else begin
          dcnt_next[k] = dcnt[k];
        end
      end
    end
  end

  always_comb newpress = stable_next & ~stable_keys;

  always_comb begin
    eff = stable_keys;
`ifdef KEY_MATRIX_GHOST_EN
    // A pressed rectangle corner (r,c2),(r2,c2),(r2,c) sneaks current into (r,c) without diodes.
    for (int unsigned r = 0; r < ROWS; r++)
      for (int unsigned c = 0; c < COLS; c++)
        for (int unsigned r2 = 0; r2 < ROWS; r2++)
          for (int unsigned c2 = 0; c2 < COLS; c2++)
            if (r2 != r && c2 != c && stable_keys[r*COLS+c2] &&
                stable_keys[r2*COLS+c2] && stable_keys[r2*COLS+c])
              eff[r*COLS+c] = 1'b1;
`endif
    m = '0;
    for (int unsigned r = 0; r < ROWS; r++)
      for (int unsigned c = 0; c < COLS; c++)
        if (strobe_q[r] && eff[r*COLS+c]) m[c] = 1'b1;
  end

  always_comb _int = (int_cnt == '0);

  always_ff @(posedge clk) begin
    if (!_reset) begin
      sync1         <= '0;
      ksync         <= '0;
      tick_cnt      <= '0;
      stable_keys   <= '0;
      for (int unsigned k = 0; k < NK; k++) dcnt[k] <= '0;
      press_evt     <= 1'b0;
      int_cnt       <= '0;
      strobe_q      <= '0;
      strobe_q_prev <= '0;
      settle_cnt    <= '0;
      ret           <= '0;
    end else begin
      sync1       <= keys;
      ksync       <= sync1;
      tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
      stable_keys <= stable_next;
      dcnt        <= dcnt_next;
      press_evt   <= |newpress;
      if (|newpress)          int_cnt <= IW'(INT_W);
      else if (int_cnt != '0) int_cnt <= int_cnt - 1'b1;

      strobe_q      <= strobe;
      strobe_q_prev <= strobe_q;
      if (SETTLE == 0)                  ret        <= m;
      else if (strobe_q != strobe_q_prev) settle_cnt <= SW'(SETTLE);
      else if (settle_cnt != '0)        settle_cnt <= settle_cnt - 1'b1;
      else                              ret        <= m;
    end
  end

endmodule
